// File: rtl/alu_sequencer_if.sv
// Request/response and ALU bus bundle for alu_sequencer.
// slave  : the sequencer's view (takes requests, drives the ALU).
// master : the environment's view (issues requests, plays the ALU).
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_out;
  logic             zero_flag;
  logic             carry_flag;
  logic             err;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [6:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;

  modport slave (
    input  start, op, a_in, b_in, alu_result, alu_zero, alu_carry,
    output busy, done, result_out, zero_flag, carry_flag, err,
           alu_a, alu_b, alu_ctrl
  );

  modport master (
    output start, op, a_in, b_in, alu_result, alu_zero, alu_carry,
    input  busy, done, result_out, zero_flag, carry_flag, err,
           alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle command front-end for the 32-bit ALU. One request is run
// as one or two ALU passes; SUB/CMP complement b first, then add.
//
// state | meaning
// IDLE  | waiting for start, ALU bus parked at 0
// P1    | first ALU pass (or skip for an illegal op code)
// P2    | second pass of SUB/CMP: a + (-b)
// WB    | ALU carry register now valid; results written on exit
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_sequencer_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NEG = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    WB   = 2'b11
  } state_t;

  state_t           state;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] tmp;
  logic [WIDTH-1:0] res_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             err_q;
  logic             done_q;

  logic             illegal;
  logic             two_pass;
  logic             arith;
  logic [WIDTH-1:0] alu_a_c;
  logic [WIDTH-1:0] alu_b_c;
  logic [6:0]       alu_ctrl_c;

  // Op-class decode of the latched op code.
  always_comb begin
    illegal  = (op_reg > OP_CMP);
    two_pass = (op_reg == OP_SUB) || (op_reg == OP_CMP);
    arith    = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
               (op_reg == OP_NEG) || (op_reg == OP_CMP);
  end

  // ALU bus, purely from state and latched operands so it is stable all pass.
  // The complement passes drive a=0 so the ALU yields -b whether or not it
  // folds a into a complemented add.
  always_comb begin
    alu_a_c    = '0;
    alu_b_c    = '0;
    alu_ctrl_c = 7'b0000000;
    case (state)
      P1: begin
        case (op_reg)
          OP_ADD: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b1000000;
          end
          OP_NEG: begin
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b1001000;
          end
          OP_AND: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0000001;
          end
          OP_XOR: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0000010;
          end
          OP_NOT: begin
            alu_a_c    = a_reg;
            alu_b_c    = '1;
            alu_ctrl_c = 7'b0000010;
          end
          OP_SLL: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0000011;
          end
          OP_SRL: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0010011;
          end
          OP_SRA: begin
            alu_a_c    = a_reg;
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0110011;
          end
          OP_SUB, OP_CMP: begin
            alu_b_c    = b_reg;
            alu_ctrl_c = 7'b0001000;
          end
          default: begin
            alu_a_c    = '0;
            alu_b_c    = '0;
            alu_ctrl_c = 7'b0000000;
          end
        endcase
      end
      P2: begin
        alu_a_c    = a_reg;
        alu_b_c    = tmp;
        alu_ctrl_c = 7'b1000000;
      end
      default: begin
        alu_a_c    = '0;
        alu_b_c    = '0;
        alu_ctrl_c = 7'b0000000;
      end
    endcase
  end

  // Sequencer FSM with registered result, flags and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      tmp      <= '0;
      res_reg  <= '0;
      zero_reg <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_reg <= bus.op;
            a_reg  <= bus.a_in;
            b_reg  <= bus.b_in;
            state  <= P1;
          end
        end
        P1: begin
          if (illegal) begin
            res_reg  <= '0;
            zero_reg <= 1'b0;
            state    <= WB;
          end else if (two_pass) begin
            tmp   <= bus.alu_result;
            state <= P2;
          end else begin
            res_reg  <= bus.alu_result;
            zero_reg <= bus.alu_zero;
            state    <= WB;
          end
        end
        P2: begin
          res_reg  <= bus.alu_result;
          zero_reg <= bus.alu_zero;
          state    <= WB;
        end
        WB: begin
          // CMP keeps the subtraction flags but reports no value.
          result_q <= (op_reg == OP_CMP) ? '0 : res_reg;
          zero_q   <= zero_reg;
          carry_q  <= arith ? bus.alu_carry : 1'b0;
          err_q    <= illegal;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.result_out = result_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.err        = err_q;
  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.alu_ctrl   = alu_ctrl_c;

endmodule
